sff_stim_check: RTL

SFF_STIM_CHECK -- requirements
Module: sff_stim_check

---
 rtl/sff_stim_check.sv | 134 +++++++++++++
 1 files changed

// File: rtl/sff_stim_check.sv
// Stimulus generator and checker for a D flop with asynchronous active-high set.
// An LFSR drives d and set; a one-bit reference model predicts q and mismatches are counted.
module sff_stim_check #(
    parameter int unsigned SET_BITS = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] num_vec,
    input  logic [7:0]  seed,
    output logic        dut_d,
    output logic        dut_set,
    input  logic        dut_q,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_cnt,
    output logic [15:0] first_err_idx
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [7:0]  lfsr_r;
    logic [15:0] vec_idx_r;
    logic [15:0] num_vec_r;
    logic        exp_r;
    logic [15:0] err_cnt_r;
    logic [15:0] first_err_idx_r;

    logic        run_s;
    logic        start_ok_s;
    logic        last_vec_s;
    logic        dut_d_s;
    logic        dut_set_s;
    logic        mismatch_s;

    assign run_s      = (state_r == ST_RUN);
    assign start_ok_s = start & ~run_s;
    assign last_vec_s = (vec_idx_r == (num_vec_r - 16'd1));
    assign dut_d_s    = run_s & lfsr_r[7];
    assign dut_set_s  = run_s & (&lfsr_r[SET_BITS-1:0]);
    // q expected now: held reference value, or 1 while set is asserted
    assign mismatch_s = (dut_q != (dut_set_s | exp_r));

    assign dut_d         = dut_d_s;
    assign dut_set       = dut_set_s;
    assign busy          = run_s;
    assign done          = (state_r == ST_DONE);
    assign pass          = (state_r == ST_DONE) && (err_cnt_r == 16'd0);
    assign err_cnt       = err_cnt_r;
    assign first_err_idx = first_err_idx_r;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt_s = (num_vec == 16'd0) ? ST_DONE : ST_RUN;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_RUN: begin
                if (last_vec_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // LFSR, vector index and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r          <= 8'h01;
            vec_idx_r       <= 16'd0;
            num_vec_r       <= 16'd0;
            err_cnt_r       <= 16'd0;
            first_err_idx_r <= 16'hFFFF;
        end else if (start_ok_s) begin
            // an all-zero seed would lock the LFSR, so it is replaced by 1
            lfsr_r          <= (seed == 8'h00) ? 8'h01 : seed;
            vec_idx_r       <= 16'd0;
            num_vec_r       <= num_vec;
            err_cnt_r       <= 16'd0;
            first_err_idx_r <= 16'hFFFF;
        end else if (run_s) begin
            lfsr_r    <= lfsr_step(lfsr_r);
            vec_idx_r <= vec_idx_r + 16'd1;
            if (mismatch_s) begin
                err_cnt_r <= sat_inc(err_cnt_r);
                if (first_err_idx_r == 16'hFFFF) begin
                    first_err_idx_r <= vec_idx_r;
                end
            end
        end
    end

    // Reference flop model, tracks the flop under test in every state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_r <= 1'b0;
        end else begin
            exp_r <= dut_set_s ? 1'b1 : dut_d_s;
        end
    end

endmodule
